// File: rtl/gate_test_pkg.sv
// -----------------------------------------------------------------------------
// gate_test_pkg
// Shared definitions for the 2-input gate test sequencer.
//   - FSM state encoding (IDLE/SETTLE/SAMPLE/DONE) and the matching enum type.
//   - Expected truth tables for common gates, indexed by {A,B}
//     (bit 0 = A0 B0, bit 3 = A1 B1).
//   - tt_lookup(): looks up the expected output for a given input vector.
// -----------------------------------------------------------------------------
package gate_test_pkg;

   // State encoding
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] SAMPLE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = IDLE,
      ST_SETTLE = SETTLE,
      ST_SAMPLE = SAMPLE,
      ST_DONE   = DONE
   } state_t;

   // Truth tables, bit index = {A,B}
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;

   // Expected gate output for input vector ab = {A,B}
   function automatic logic tt_lookup(input logic [3:0] tt, input logic [1:0] ab);
      return tt[ab];
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Single-bit two-flop synchroniser for bringing an asynchronous or off-chip
// signal into the i_clk domain. Both stages reset to 0.
// Ports:
//   i_clk    : destination clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_d      : asynchronous input
//   o_q      : synchronised output, two cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/gate_test_seq.sv
// -----------------------------------------------------------------------------
// gate_test_seq
// Self-checking sequencer for a 2-input combinational gate. On a start pulse it
// drives {A,B} = 00,01,10,11 in turn, holds each vector for a settle period,
// samples the gate output and compares it with the EXP_TT truth table.
//
// Parameters:
//   SETTLE_CYC : cycles each vector is held before sampling (1..255)
//   EXP_TT     : expected output indexed by {A,B}, default AND
//   CNT_W      : settle counter width
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   start      in   single-cycle request to run one sweep (ignored when busy)
//   gate_y     in   output of the gate under test
//   gate_a     out  A input of the gate under test (registered)
//   gate_b     out  B input of the gate under test (registered)
//   busy       out  high from the start edge until the cycle before done
//   done       out  one-cycle pulse at the end of the sweep
//   pass       out  1 when no vector mismatched; valid from done to next start
//   fail_vec   out  bit k set if vector k mismatched
//   err_cnt    out  number of mismatching vectors (0..4)
//
// Build option:
//   GATE_Y_SYNC_EN : gate_y passes through a 2-flop synchroniser before the
//                    comparison; the settle period grows by 2 cycles to cover
//                    the synchroniser latency.
// -----------------------------------------------------------------------------
module gate_test_seq
   import gate_test_pkg::*;
#(
   parameter int         SETTLE_CYC = 4,
   parameter logic [3:0] EXP_TT     = TT_AND,
   parameter int         CNT_W      = 8
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       start,
   input  logic       gate_y,
   output logic       gate_a,
   output logic       gate_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_vec,
   output logic [2:0] err_cnt
);

   // Last counter value spent in SETTLE before moving to SAMPLE.
`ifdef GATE_Y_SYNC_EN
   localparam int SETTLE_LAST = SETTLE_CYC + 1;
`else
   localparam int SETTLE_LAST = SETTLE_CYC - 1;
`endif
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_LAST);

   state_t           r_state;
   logic [1:0]       r_idx;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_ab;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [3:0]       r_fail_vec;
   logic [2:0]       r_err_cnt;

   logic             w_y;
   logic             w_mis;

   // Gate output as seen by the comparator
`ifdef GATE_Y_SYNC_EN
   sync_2ff u_sync_y (
      .i_clk   (sys_clk),
      .i_rst_n (sys_rst_n),
      .i_d     (gate_y),
      .o_q     (w_y)
   );
`else
   assign w_y = gate_y;
`endif

   assign w_mis = (w_y != tt_lookup(EXP_TT, r_idx));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state    <= ST_IDLE;
         r_idx      <= 2'd0;
         r_cnt      <= '0;
         r_ab       <= 2'b00;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_fail_vec <= 4'b0000;
         r_err_cnt  <= 3'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state    <= ST_SETTLE;
                  r_idx      <= 2'd0;
                  r_ab       <= 2'b00;
                  r_cnt      <= '0;
                  r_fail_vec <= 4'b0000;
                  r_err_cnt  <= 3'd0;
                  r_pass     <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end

            ST_SETTLE: begin
               // Counter free-runs here; it is re-zeroed when the next vector
               // is launched, so any wrap past CNT_LAST is never observed.
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state <= ST_SAMPLE;
               end
            end

            ST_SAMPLE: begin
               if (w_mis) begin
                  r_fail_vec[r_idx] <= 1'b1;
                  r_err_cnt         <= r_err_cnt + 3'd1;
               end
               if (r_idx != 2'd3) begin
                  r_idx   <= r_idx + 2'd1;
                  r_ab    <= r_idx + 2'd1;
                  r_cnt   <= '0;
                  r_state <= ST_SETTLE;
               end else begin
                  // Final vector: the registered fail_vec does not yet include
                  // this vector's result, so fold w_mis in explicitly.
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (r_fail_vec == 4'b0000) && !w_mis;
               end
            end

            ST_DONE: begin
               // Vector 11 stays on the gate until the next start.
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign gate_a   = r_ab[1];
   assign gate_b   = r_ab[0];
   assign busy     = r_busy;
   assign done     = r_done;
   assign pass     = r_pass;
   assign fail_vec = r_fail_vec;
   assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_gate_test_seq.sv
// -----------------------------------------------------------------------------
// tb_gate_test_seq
// Drives gate_test_seq (default parameters: SETTLE_CYC=4, EXP_TT=AND) against a
// behavioural gate whose truth table is chosen per sweep. Expected sweep
// results are queued when a sweep is launched and popped on each done pulse;
// a cycle-level timing model checks busy/done/vector/result outputs.
// -----------------------------------------------------------------------------
module tb_gate_test_seq;

   localparam int S = 4;
`ifdef GATE_Y_SYNC_EN
   localparam int P = S + 3;
`else
   localparam int P = S + 1;
`endif
   localparam int SWEEP = 4 * P;            // done appears after this edge
   localparam logic [3:0] EXP = 4'b1000;    // AND truth table, index {A,B}

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] gate_tt = 4'b1000;
   logic       gate_y;
   logic       gate_a, gate_b, busy, done, pass;
   logic [3:0] fail_vec;
   logic [2:0] err_cnt;

   gate_test_seq dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .start     (start),
      .gate_y    (gate_y),
      .gate_a    (gate_a),
      .gate_b    (gate_b),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_vec  (fail_vec),
      .err_cnt   (err_cnt)
   );

   // Behavioural gate under test
   assign gate_y = gate_tt[{gate_a, gate_b}];

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] fv;
      logic [2:0] ec;
      logic       ps;
   } exp_t;
   exp_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t predict(input logic [3:0] tt);
      exp_t e;
      e.fv = tt ^ EXP;
      e.ec = 3'($countones(e.fv));
      e.ps = (e.fv == 4'b0000);
      return e;
   endfunction

   // ---------------- cycle-level timing model ----------------
   // m_e = edges since the accepting start edge, -1 when idle.
   int         m_e = -1;
   logic [3:0] m_mis = 4'b0;
   logic [3:0] m_fv = 4'b0;
   logic       m_pass = 1'b0;
   logic [1:0] m_ab = 2'b00;

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_e = -1; m_fv = 4'b0; m_pass = 1'b0; m_ab = 2'b00;
         end else if (m_e < 0) begin
            if (start) begin
               m_e = 0; m_mis = gate_tt ^ EXP; m_fv = 4'b0; m_pass = 1'b0; m_ab = 2'b00;
            end
         end else begin
            m_e++;
            if (m_e > SWEEP) begin
               m_e = -1;
            end else begin
               if (m_e % P == 0) begin
                  int k;
                  k = m_e / P - 1;
                  m_fv[k] = m_mis[k];
               end
               if (m_e == SWEEP) m_pass = (m_fv == 4'b0000);
               m_ab = (m_e / P > 3) ? 2'd3 : 2'(m_e / P);
            end
         end
         #1;
         chk("busy",     busy,     (m_e >= 0 && m_e < SWEEP));
         chk("done",     done,     (m_e == SWEEP));
         chk("gate_ab",  {gate_a, gate_b}, m_ab);
         chk("fail_vec", fail_vec, m_fv);
         chk("err_cnt",  err_cnt,  $countones(m_fv));
         chk("pass",     pass,     m_pass);
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected_done actual=done required=no_done t=%0t", $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("sb_fail_vec", fail_vec, e.fv);
               chk("sb_err_cnt",  err_cnt,  e.ec);
               chk("sb_pass",     pass,     e.ps);
               $display("sweep result fail_vec=%b err_cnt=%0d pass=%0d t=%0t",
                        fail_vec, err_cnt, pass, $time);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_idle();
      int n = 0;
      while (m_e != -1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (m_e != -1) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout actual=busy required=idle t=%0t", $time);
      end
   endtask

   task automatic sweep(input logic [3:0] tt, input bit extra);
      wait_idle();
      gate_tt = tt;
      start   = 1'b1;
      exp_q.push_back(predict(tt));
      $display("sweep start gate_tt=%b extra_starts=%0d t=%0t", tt, extra, $time);
      for (int e = 1; e <= SWEEP + 1; e++) begin
         @(negedge clk);
         start = extra && (e == 3 || e == 12);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic back_to_back(input logic [3:0] tt);
      wait_idle();
      gate_tt = tt;
      start   = 1'b1;
      exp_q.push_back(predict(tt));
      exp_q.push_back(predict(tt));
      $display("back-to-back sweeps gate_tt=%b t=%0t", tt, $time);
      for (int e = 1; e <= 2 * (SWEEP + 2) - 1; e++) @(negedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic reset_mid_sweep();
      wait_idle();
      gate_tt = EXP;
      start   = 1'b1;
      exp_q.push_back(predict(EXP));
      $display("sweep with mid-sweep reset t=%0t", $time);
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("rst_busy",     busy,     1'b0);
      chk("rst_done",     done,     1'b0);
      chk("rst_pass",     pass,     1'b0);
      chk("rst_gate_ab",  {gate_a, gate_b}, 2'b00);
      chk("rst_fail_vec", fail_vec, 4'b0000);
      chk("rst_err_cnt",  err_cnt,  3'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy",     busy,     1'b0);
      chk("reset_done",     done,     1'b0);
      chk("reset_pass",     pass,     1'b0);
      chk("reset_gate_ab",  {gate_a, gate_b}, 2'b00);
      chk("reset_fail_vec", fail_vec, 4'b0000);
      chk("reset_err_cnt",  err_cnt,  3'd0);
      rst_n = 1'b1;
      @(negedge clk);

      sweep(4'b1000, 1'b0);              // matching AND gate
      sweep(4'b1110, 1'b0);              // OR gate: vectors 1,2 mismatch
      sweep(4'b1111, 1'b0);              // stuck-at-1: vectors 0..2 mismatch
      repeat (10) @(negedge clk);        // results must hold while idle
      sweep(4'b1000, 1'b1);              // extra starts mid-sweep ignored
      reset_mid_sweep();
      sweep(4'b1000, 1'b0);              // clean pass after reset
      back_to_back(4'($urandom_range(0, 15)));
      for (int i = 0; i < 6; i++) begin
         sweep(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      wait_idle();
      repeat (3) @(negedge clk);
      chk("sb_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gate_test_seq.md
Name: gate_test_seq

Overview:
Self-checking sequencer for a 2-input combinational gate under test, such as the team's and_gate.
- On a start pulse, drives all four input combinations {A,B} = 00, 01, 10, 11 in order onto the gate.
- Waits a programmable settle time after each vector, samples Y and compares it against a parameterised expected truth table.
- Reports per-vector fail flags, a mismatch count and a pass/done summary; used on-board and as the bench-side stimulus engine.

Parameters:
- SETTLE_CYC, 4: clock cycles each vector is held before Y is sampled. Legal range 1..255.
- EXP_TT, 4'b1000: expected Y indexed by {A,B}. Bit 0 is the result for A=0,B=0; bit 3 for A=1,B=1. Default is AND.
- CNT_W, 8: width of the settle counter. Must hold SETTLE_CYC-1.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to run one sweep.
- gate_y  input  1  output of the gate under test.
- gate_a  output  1  A input to the gate under test; registered.
- gate_b  output  1  B input to the gate under test; registered.
- busy  output  1  high from the start edge through the cycle before done.
- done  output  1  one-cycle pulse when the sweep completes.
- pass  output  1  1 when fail_vec==0. Valid from done until the next accepted start.
- fail_vec  output  4  bit k set if vector k mismatched.
- err_cnt  output  3  number of mismatching vectors, 0..4.

Behaviour:
- Reset (sys_rst_n low, asynchronous) forces the following. Deassertion is synchronous to sys_clk.
  - state=IDLE.
  - gate_a=0, gate_b=0.
  - busy=0, done=0, pass=0.
  - fail_vec=0, err_cnt=0.
  - Internal idx=0, cnt=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 at an edge -> SETTLE.
  - At that edge: idx<=0, {gate_a,gate_b}<=2'b00, cnt<=0, fail_vec<=0, err_cnt<=0, pass<=0, busy<=1.
- SETTLE:
  - cnt increments each edge.
  - When cnt==SETTLE_CYC-1 -> SAMPLE.
  - gate_a/gate_b are held stable throughout.
- SAMPLE (one cycle):
  - Compare gate_y against EXP_TT[idx].
  - On mismatch: fail_vec[idx]<=1 and err_cnt<=err_cnt+1.
  - If idx<3: idx<=idx+1, {gate_a,gate_b}<=idx+1, cnt<=0 -> SETTLE.
  - If idx==3 -> DONE, with busy<=0, done<=1, and pass<=1 if no mismatch including the current vector.
- DONE (one cycle): done high, then done<=0 -> IDLE.
  - gate_a/gate_b keep 2'b11 until the next start.
- Timing:
  - Vector k is sampled at edge (k+1)*(SETTLE_CYC+1), counting the start edge as 0.
  - done is high in the cycle after edge 4*(SETTLE_CYC+1). With default parameters that is edge 20.
- start while busy or in DONE is ignored; there is no queueing.
- start held high continuously gives back-to-back sweeps: it is re-accepted in the first IDLE cycle.
- pass, fail_vec and err_cnt hold their values after done until the next accepted start clears them.
- Reset during a sweep aborts it immediately. No done pulse is produced and the results are cleared.
- err_cnt cannot overflow, because there are at most 4 mismatches.

Optional Feature:
- Macro GATE_Y_SYNC_EN.
- When defined:
  - gate_y passes through a 2-flop synchroniser, reset to 0, before the comparison. This supports asynchronous or off-chip gates.
  - The effective settle becomes SETTLE_CYC+2. SETTLE exits at cnt==SETTLE_CYC+1, so each vector takes SETTLE_CYC+3 cycles.
  - done arrives at edge 4*(SETTLE_CYC+3).
  - CNT_W must hold SETTLE_CYC+1.
- When undefined: gate_y is compared directly and the timing is as given in Behaviour.

Decomposition:
- Package gate_test_pkg holds:
  - State encoding localparams: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3.
  - Truth-table constants: TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001.
- Sub-module sync_2ff, 1-bit with async active-low reset, instantiated only under GATE_Y_SYNC_EN.
- Everything else stays flat in gate_test_seq.

Test Plan:
1. EXP_TT=TT_AND, SETTLE_CYC=4, DUT=and_gate; pulse start -> gate_a/gate_b step through 00,01,10,11 every 5 cycles; done at edge 20; pass=1, fail_vec=0000, err_cnt=0.
2. EXP_TT=TT_AND, gate_y driven by an OR model -> done at edge 20; pass=0, fail_vec=0110, err_cnt=2.
3. gate_y stuck at 1 with EXP_TT=TT_AND -> fail_vec=0111, err_cnt=3, pass=0. Results hold for 10 idle cycles, then clear on the next start.
4. Extra start pulses at edges 3 and 12 of a running sweep -> ignored: exactly one done, at edge 20, and busy stays high throughout.
5. sys_rst_n asserted at edge 8 mid-sweep -> all outputs go to 0 immediately; no done; a new start after release gives a clean pass.
6. GATE_Y_SYNC_EN defined, SETTLE_CYC=4, and_gate -> samples at edges 7/14/21/28; done at edge 28; pass=1.
